disp_scan: RTL

DISP_SCAN -- requirements
Module: disp_scan

---
 rtl/disp_scan_pkg.sv | 28 ++
 rtl/disp_scan_bin2bcd.sv | 68 ++++++
 rtl/disp_scan.sv | 126 ++++++++++++
 3 files changed

// File: rtl/disp_scan_pkg.sv
// Shared constants for the multiplexed display scanner: segment glyphs,
// default scan/blink rates and the converter state type.
package disp_scan_pkg;

  localparam int SCAN_DIV_DEFAULT    = 100000;
  localparam int BLINK_SLOTS_DEFAULT = 250;

  typedef logic [7:0] glyph_t;

  localparam glyph_t GLYPH_BLANK = 8'h00;
  localparam glyph_t GLYPH_MINUS = 8'h40;

  // Entry 9 listed first so that GLYPH_DIGITS[d] is the glyph for d.
  localparam logic [9:0][7:0] GLYPH_DIGITS = {
    8'h6F, 8'h7F, 8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };

  typedef enum logic [1:0] {
    CONV_IDLE,
    CONV_SHIFT,
    CONV_DONE
  } conv_state_t;

  function automatic glyph_t digit_glyph(input logic [3:0] d);
    return (d <= 4'd9) ? GLYPH_DIGITS[d] : GLYPH_BLANK;
  endfunction

endpackage

// File: rtl/disp_scan_bin2bcd.sv
// Sequential shift-add-3 binary to BCD converter: 12 shift cycles after
// start, then a one-cycle done with the four BCD digits held stable.
module bin2bcd
  import disp_scan_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [11:0]     bin_in,
  output logic            busy,
  output logic            done,
  output logic [3:0][3:0] bcd
);

  conv_state_t     state, state_nxt;
  logic [3:0]      cnt, cnt_nxt;
  logic [11:0]     sh_bin, bin_nxt;
  logic [3:0][3:0] sh_bcd, bcd_nxt, adj;
  logic [27:0]     shifted;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= CONV_IDLE;
      cnt    <= '0;
      sh_bin <= '0;
      sh_bcd <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      sh_bin <= bin_nxt;
      sh_bcd <= bcd_nxt;
    end
  end

  always_comb begin
    adj = sh_bcd;
    for (int i = 0; i < 4; i++) begin
      if (sh_bcd[i] >= 4'd5) adj[i] = sh_bcd[i] + 4'd3;
    end
    shifted   = {adj, sh_bin} << 1;
    state_nxt = state;
    cnt_nxt   = cnt;
    bin_nxt   = sh_bin;
    bcd_nxt   = sh_bcd;
    case (state)
      CONV_IDLE: begin
        if (start) begin
          state_nxt = CONV_SHIFT;
          cnt_nxt   = '0;
          bin_nxt   = bin_in;
          bcd_nxt   = '0;
        end
      end
      CONV_SHIFT: begin
        {bcd_nxt, bin_nxt} = shifted;
        cnt_nxt = cnt + 4'd1;
        if (cnt == 4'd11) state_nxt = CONV_DONE;
      end
      CONV_DONE: state_nxt = CONV_IDLE;
      default:   state_nxt = CONV_IDLE;
    endcase
  end

  assign busy = (state != CONV_IDLE);
  assign done = (state == CONV_DONE);
  assign bcd  = sh_bcd;

endmodule

// File: rtl/disp_scan.sv
// Two-group 4-digit multiplexed LED display: signed balance on the right,
// mode number and sign on the left, with per-digit blinking.
module disp_scan
  import disp_scan_pkg::*;
#(
  parameter int SCAN_DIV    = SCAN_DIV_DEFAULT,
  parameter int BLINK_SLOTS = BLINK_SLOTS_DEFAULT
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [10:0] value,
  input  logic [2:0]  mode_code,
  input  logic [7:0]  blink_mask,
  output logic        busy,
  output logic [3:0]  ena_l,
  output logic [3:0]  ena_r,
  output logic [7:0]  l_light,
  output logic [7:0]  r_light
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;
  localparam logic [DW-1:0] DIV_LAST   = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_SLOTS - 1);

  logic [11:0]     mag;
  logic            start, conv_done;
  logic [3:0][3:0] bcd;
  logic            neg_q;
  logic [2:0]      mode_q;
  glyph_t [3:0]    dig_r, dig_l;

  logic [DW-1:0]   div;
  logic            tick;
  logic [1:0]      idx, shown, slot_nxt;
  logic            active, active_nxt;
  logic            phase_on, phase_nxt;
  logic [BW-1:0]   blink_cnt;
  logic [3:0]      ena;
  glyph_t          r_nxt, l_nxt;

  // 12-bit magnitude so that -1024 converts as 1024.
  assign mag   = value[10] ? (12'd0 - {1'b1, value}) : {1'b0, value};
  assign start = load && !busy;

  bin2bcd u_conv (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .bin_in (mag),
    .busy   (busy),
    .done   (conv_done),
    .bcd    (bcd)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      neg_q  <= 1'b0;
      mode_q <= '0;
      dig_r  <= '0;
      dig_l  <= '0;
    end else begin
      if (start) begin
        neg_q  <= value[10];
        mode_q <= mode_code;
      end
      if (conv_done) begin
        dig_r[3] <= (bcd[3] == 4'd0) ? GLYPH_BLANK : digit_glyph(bcd[3]);
        dig_r[2] <= (bcd[3:2] == 8'd0) ? GLYPH_BLANK : digit_glyph(bcd[2]);
        dig_r[1] <= (bcd[3:1] == 12'd0) ? GLYPH_BLANK : digit_glyph(bcd[1]);
        dig_r[0] <= digit_glyph(bcd[0]);
        dig_l[3] <= digit_glyph({1'b0, mode_q});
        dig_l[2] <= GLYPH_BLANK;
        dig_l[1] <= GLYPH_BLANK;
        dig_l[0] <= neg_q ? GLYPH_MINUS : GLYPH_BLANK;
      end
    end
  end

  // The slot shown after a tick is the index before it advances, so the
  // first tick out of reset enables digit 0.
  always_comb begin
    tick       = (div == DIV_LAST);
    slot_nxt   = tick ? idx : shown;
    active_nxt = active | tick;
    phase_nxt  = (tick && blink_cnt == BLINK_LAST) ? ~phase_on : phase_on;
    r_nxt      = GLYPH_BLANK;
    l_nxt      = GLYPH_BLANK;
    if (active_nxt && (phase_nxt || !blink_mask[{1'b0, slot_nxt}]))
      r_nxt = dig_r[slot_nxt];
    if (active_nxt && (phase_nxt || !blink_mask[{1'b1, slot_nxt}]))
      l_nxt = dig_l[slot_nxt];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div       <= '0;
      idx       <= '0;
      shown     <= '0;
      active    <= 1'b0;
      phase_on  <= 1'b1;
      blink_cnt <= '0;
      ena       <= '0;
      r_light   <= '0;
      l_light   <= '0;
    end else begin
      div <= tick ? '0 : div + DW'(1);
      if (tick) begin
        idx       <= idx + 2'd1;
        blink_cnt <= (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + BW'(1);
      end
      shown    <= slot_nxt;
      active   <= active_nxt;
      phase_on <= phase_nxt;
      ena      <= active_nxt ? (4'b0001 << slot_nxt) : 4'b0000;
      r_light  <= r_nxt;
      l_light  <= l_nxt;
    end
  end

  assign ena_l = ena;
  assign ena_r = ena;

endmodule
